// File: rtl/data_mem.sv
// data_mem: load/store responder for the CPU data port.
// Accepts one request at a time (req sampled only while idle), waits
// WAIT_STATES cycles, then gives a one-cycle ready strobe with registered
// rdata and err. Handles RISC-V byte/half/word accesses, including
// sign- and zero-extending loads and byte-lane stores.
//
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous active-low reset
//   req     request valid (ignored while busy)
//   we      1 = store, 0 = load
//   addr    byte address (wraps modulo 4*DEPTH_WORDS)
//   funct3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   wdata   store data, right-aligned
//   rdata   load result, held until the next load or error response
//   ready   one-cycle response strobe
//   err     response is an error, valid with ready
//   busy    request in flight
//
// state | meaning
// IDLE  | waiting for req
// WAIT  | counting wait states for the accepted request
// RESP  | ready=1 for one cycle, rdata/err valid
module data_mem #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic        commit;

    logic [31:0] mem [DEPTH_WORDS];

    // In IDLE the live inputs are used so that a zero-wait request can be
    // committed on its accept edge; afterwards the latched copy is used.
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [2:0]  cur_funct3;
    logic [31:0] cur_wdata;
    logic        cur_err;
    logic [AW-1:0] idx;
    logic [31:0] word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_val;
    logic [3:0]  lane_en;
    logic [31:0] lane_data;
    logic        addr_unused;

    assign addr_unused = ^cur_addr[31:AW+2];

    always_comb begin
        cur_we     = (state == IDLE) ? we     : we_q;
        cur_addr   = (state == IDLE) ? addr   : addr_q;
        cur_funct3 = (state == IDLE) ? funct3 : funct3_q;
        cur_wdata  = (state == IDLE) ? wdata  : wdata_q;
    end

    assign idx  = cur_addr[AW+1:2];
    assign word = mem[idx];

    always_comb begin
        cur_err = 1'b0;
        case (cur_funct3)
            3'b000:         cur_err = 1'b0;
            3'b001:         cur_err = cur_addr[0];
            3'b010:         cur_err = (cur_addr[1:0] != 2'b00);
            3'b100, 3'b101: cur_err = cur_we;
            default:        cur_err = 1'b1;
        endcase
    end

    always_comb begin
        sel_byte = word[7:0];
        case (cur_addr[1:0])
            2'd0: sel_byte = word[7:0];
            2'd1: sel_byte = word[15:8];
            2'd2: sel_byte = word[23:16];
            2'd3: sel_byte = word[31:24];
            default: sel_byte = word[7:0];
        endcase
        sel_half = cur_addr[1] ? word[31:16] : word[15:0];
        load_val = word;
        case (cur_funct3)
            3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_val = {24'd0, sel_byte};
            3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_val = {16'd0, sel_half};
            default: load_val = word;
        endcase
    end

    always_comb begin
        lane_en   = 4'b0000;
        lane_data = cur_wdata;
        case (cur_funct3)
            3'b000: begin
                lane_en   = 4'b0001 << cur_addr[1:0];
                lane_data = {4{cur_wdata[7:0]}};
            end
            3'b001: begin
                lane_en   = cur_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cur_wdata[15:0]}};
            end
            3'b010: lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    end

    // commit marks the edge that enters RESP
    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
                    commit    = (WAIT_STATES == 0);
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            wdata_q  <= 32'd0;
            err_q    <= 1'b0;
            rdata    <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                we_q     <= we;
                addr_q   <= addr;
                funct3_q <= funct3;
                wdata_q  <= wdata;
                cnt      <= CNT_LOAD;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                err_q <= cur_err;
                if (cur_err)
                    rdata <= 32'd0;
                else if (!cur_we)
                    rdata <= load_val;
            end else begin
                err_q <= 1'b0;
            end
        end
    end

    // Storage is not reset; reset gates the write so a zero-wait request
    // seen during reset cannot modify memory.
    always_ff @(posedge clock) begin
        if (commit && cur_we && !cur_err && reset) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i])
                    mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    assign ready = (state == RESP);
    assign busy  = (state != IDLE);
    assign err   = err_q;

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [2:0]  req_v;
    logic [2:0]  rst_v;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [31:0] wdata;
    logic [31:0] rdata_v [3];
    logic        ready_v [3];
    logic        err_v   [3];
    logic        busy_v  [3];

    data_mem #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (
        .clock(clock), .reset(rst_v[0]), .req(req_v[0]), .we(we), .addr(addr),
        .funct3(funct3), .wdata(wdata), .rdata(rdata_v[0]), .ready(ready_v[0]),
        .err(err_v[0]), .busy(busy_v[0]));
    data_mem #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_dut1 (
        .clock(clock), .reset(rst_v[1]), .req(req_v[1]), .we(we), .addr(addr),
        .funct3(funct3), .wdata(wdata), .rdata(rdata_v[1]), .ready(ready_v[1]),
        .err(err_v[1]), .busy(busy_v[1]));
    data_mem #(.DEPTH_WORDS(256), .WAIT_STATES(4)) u_dut4 (
        .clock(clock), .reset(rst_v[2]), .req(req_v[2]), .we(we), .addr(addr),
        .funct3(funct3), .wdata(wdata), .rdata(rdata_v[2]), .ready(ready_v[2]),
        .err(err_v[2]), .busy(busy_v[2]));

    typedef struct {
        int          k;
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int ws(int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 4);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
        end
    endtask

    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (err_v[k] && !ready_v[k])
                check("err_outside_resp", 32'(err_v[k]), 32'd0);
            if (ready_v[k]) begin
                if (sb.size() == 0) begin
                    check("spurious_ready", 32'(ready_v[k]), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("instance", 32'(k), 32'(mon_e.k));
                    check("rdata", rdata_v[k], mon_e.rdata);
                    check("err", 32'(err_v[k]), 32'(mon_e.err));
                    check("latency", 32'(cyc - mon_e.acc), 32'(ws(k) + 1));
                end
            end
        end
    end

    task automatic xact(int k, logic w, logic [31:0] a, logic [2:0] f,
                        logic [31:0] d, logic [31:0] er, logic ee, bit poke);
        exp_t e;
        @(negedge clock);
        we = w; addr = a; funct3 = f; wdata = d;
        req_v[k] = 1'b1;
        @(posedge clock);
        e.k = k; e.rdata = er; e.err = ee; e.acc = cyc;
        sb.push_back(e);
        @(negedge clock);
        req_v[k] = 1'b0;
        we = 1'($urandom); addr = $urandom; funct3 = 3'($urandom); wdata = $urandom;
        check("busy_after_accept", 32'(busy_v[k]), 32'd1);
        if (poke) begin
            req_v[k] = 1'b1; we = 1'b1; addr = 32'h0; funct3 = 3'b010; wdata = 32'h0;
            @(negedge clock);
            req_v[k] = 1'b0;
        end
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
        check("response_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clock);
        check("ready_single", 32'(ready_v[k]), 32'd0);
        check("busy_idle", 32'(busy_v[k]), 32'd0);
    endtask

    initial begin
        req_v = 3'b000; rst_v = 3'b000;
        we = 1'b0; addr = 32'h0; funct3 = 3'b000; wdata = 32'h0;
        repeat (3) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            check("reset_ready", 32'(ready_v[k]), 32'd0);
            check("reset_err",   32'(err_v[k]),   32'd0);
            check("reset_busy",  32'(busy_v[k]),  32'd0);
            check("reset_rdata", rdata_v[k],      32'd0);
        end
        rst_v = 3'b111;

        // word round trip, sized loads, lane stores, errors (1 wait state)
        xact(1, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0);
        xact(1, 1'b0, 32'h10, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
        xact(1, 1'b1, 32'h08, 3'b010, 32'h80F17F01, 32'hDEADBEEF, 1'b0, 1'b0);
        xact(1, 1'b0, 32'h08, 3'b000, 32'h0,        32'h00000001, 1'b0, 1'b0);
        xact(1, 1'b0, 32'h0B, 3'b000, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0);
        xact(1, 1'b0, 32'h0B, 3'b100, 32'h0,        32'h00000080, 1'b0, 1'b0);
        xact(1, 1'b0, 32'h0A, 3'b001, 32'h0,        32'hFFFF80F1, 1'b0, 1'b0);
        xact(1, 1'b0, 32'h0A, 3'b101, 32'h0,        32'h000080F1, 1'b0, 1'b0);
        xact(1, 1'b1, 32'h20, 3'b010, 32'h11223344, 32'h000080F1, 1'b0, 1'b0);
        xact(1, 1'b1, 32'h21, 3'b000, 32'h123456AB, 32'h000080F1, 1'b0, 1'b0);
        xact(1, 1'b1, 32'h22, 3'b001, 32'h9999CDEF, 32'h000080F1, 1'b0, 1'b0);
        xact(1, 1'b0, 32'h20, 3'b010, 32'h0,        32'hCDEFAB44, 1'b0, 1'b0);
        xact(1, 1'b1, 32'h30, 3'b010, 32'h55667788, 32'hCDEFAB44, 1'b0, 1'b0);
        xact(1, 1'b1, 32'h31, 3'b001, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0);
        xact(1, 1'b0, 32'h30, 3'b010, 32'h0,        32'h55667788, 1'b0, 1'b0);
        xact(1, 1'b0, 32'h30, 3'b011, 32'h0,        32'h0,        1'b1, 1'b0);
        xact(1, 1'b0, 32'h30, 3'b010, 32'h0,        32'h55667788, 1'b0, 1'b0);
        xact(1, 1'b0, 32'h22, 3'b010, 32'h0,        32'h0,        1'b1, 1'b0);
        xact(1, 1'b1, 32'h30, 3'b100, 32'h000000EE, 32'h0,        1'b1, 1'b0);
        xact(1, 1'b0, 32'h30, 3'b010, 32'h0,        32'h55667788, 1'b0, 1'b0);

        // zero wait states, address wrap, req during RESP ignored
        xact(0, 1'b1, 32'h400, 3'b010, 32'h5A5A5A5A, 32'h0,        1'b0, 1'b0);
        xact(0, 1'b0, 32'h000, 3'b010, 32'h0,        32'h5A5A5A5A, 1'b0, 1'b1);
        xact(0, 1'b0, 32'h000, 3'b010, 32'h0,        32'h5A5A5A5A, 1'b0, 1'b0);

        // reset in the middle of a store (4 wait states)
        xact(2, 1'b1, 32'h40, 3'b010, 32'h00000000, 32'h0,        1'b0, 1'b0);
        xact(2, 1'b1, 32'h44, 3'b010, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0);
        xact(2, 1'b0, 32'h44, 3'b010, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0);
        @(negedge clock);
        we = 1'b1; addr = 32'h40; funct3 = 3'b010; wdata = 32'h12345678;
        req_v[2] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_v[2] = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 rst_v[2] = 1'b0;
        @(negedge clock);
        check("midrst_busy",  32'(busy_v[2]),  32'd0);
        check("midrst_ready", 32'(ready_v[2]), 32'd0);
        check("midrst_rdata", rdata_v[2],      32'd0);
        rst_v[2] = 1'b1;
        repeat (8) @(negedge clock);
        check("midrst_busy_after", 32'(busy_v[2]), 32'd0);
        xact(2, 1'b0, 32'h40, 3'b010, 32'h0, 32'h00000000, 1'b0, 1'b0);

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
